// File: rtl/truth_table_checker.sv
// Sweeps all 2**N_IN input vectors into a combinational DUT and checks each response against EXPECTED.
// Latency: vector i is compared SETTLE+1 cycles after it is driven; done rises 2**N_IN*(SETTLE+1) cycles after start.
// Backpressure: none; start is level-sampled and ignored while busy, so a new sweep begins only from IDLE or DONE.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             sweep request, accepted only in IDLE or DONE
//   dut_y             response of the block under test, sampled only in CHECK
//   stim              vector driven into the block under test (MSB = input a)
//   busy/done/pass    sweep status; pass = done with no mismatches
//   err_count         number of mismatching vectors in the current run
//   first_fail_idx/_vld  index of the earliest mismatch in the current run
module truth_table_checker #(
    parameter int                    N_IN     = 4,
    parameter int                    SETTLE   = 2,   // must be >= 1
    parameter logic [(2**N_IN)-1:0]  EXPECTED = 16'h8000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dut_y,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail_idx,
    output logic              first_fail_vld
);

    localparam int              NV      = 2**N_IN;
    localparam int              CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_END = CW'(SETTLE - 1);
    localparam logic [N_IN:0]   ERR_MAX = (N_IN+1)'(NV);
    localparam logic [N_IN-1:0] IDX_END = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q,   idx_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [N_IN-1:0] stim_q,  stim_d;
    logic [N_IN:0]   err_q,   err_d;
    logic [N_IN-1:0] ffi_q,   ffi_d;
    logic            ffv_q,   ffv_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic            pass_q,  pass_d;
    logic            mismatch;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            stim_q  <= '0;
            err_q   <= '0;
            ffi_q   <= '0;
            ffv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
            ffv_q   <= ffv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign mismatch = (dut_y != EXPECTED[idx_q]);

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        err_d   = err_q;
        ffi_d   = ffi_q;
        ffv_d   = ffv_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_d   = '0;
                    ffi_d   = '0;
                    ffv_d   = 1'b0;
                    idx_d   = '0;
                    stim_d  = '0;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_END) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    // Can never exceed one error per vector; the guard just makes that explicit.
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + (N_IN+1)'(1);
                    end
                    if (!ffv_q) begin
                        ffi_d = idx_q;
                        ffv_d = 1'b1;
                    end
                end
                if (idx_q == IDX_END) begin
                    // stim keeps the last vector while results are held in DONE
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + N_IN'(1);
                    stim_d  = idx_q + N_IN'(1);
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags are decoded from the next state so they are registered like everything else.
    always_comb begin
        busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (err_d == '0);
    end

    assign stim           = stim_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;
    assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: a behavioural block-under-test answers stim, and
// a reference computes the expected sweep results from the checker's behaviour description.
module tb_truth_table_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        dut_y;
    logic [3:0]  stim;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic [3:0]  first_fail_idx;
    logic        first_fail_vld;

    int checks = 0;
    int errors = 0;

    logic [15:0] resp_tbl;   // response of the emulated block for each stim value
    logic [15:0] gold_tbl;   // a&b&c&d, computed arithmetically

    truth_table_checker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .dut_y          (dut_y),
        .stim           (stim),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_idx (first_fail_idx),
        .first_fail_vld (first_fail_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Emulated 4-input combinational block
    always_comb dut_y = resp_tbl[stim];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one sweep; optionally pulse start again mid-run or reset mid-run.
    task automatic run_sweep(input string name, input bit pulse10, input bit rst20);
        int exp_err;
        int exp_ffi;
        bit exp_ffv;
        int hold;
        int expect_stim;
        exp_err = 0;
        exp_ffi = 0;
        exp_ffv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (resp_tbl[i] != gold_tbl[i]) begin
                exp_err++;
                if (!exp_ffv) begin
                    exp_ffi = i;
                    exp_ffv = 1'b1;
                end
            end
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);            // edge E0
        #1;
        start = 1'b0;
        chk({name, ":start_stim"}, 32'(stim), 32'd0);
        chk({name, ":start_busy"}, 32'(busy), 32'd1);
        chk({name, ":start_done"}, 32'(done), 32'd0);
        hold = 1;
        expect_stim = 0;
        for (int k = 1; k <= 48; k++) begin
            @(posedge clk);
            #1;
            if (rst20 && k == 20) begin
                rst_n = 1'b0;
                #1;
                chk({name, ":rst_stim"}, 32'(stim), 32'd0);
                chk({name, ":rst_busy"}, 32'(busy), 32'd0);
                chk({name, ":rst_done"}, 32'(done), 32'd0);
                chk({name, ":rst_pass"}, 32'(pass), 32'd0);
                chk({name, ":rst_err"}, 32'(err_count), 32'd0);
                chk({name, ":rst_ffi"}, 32'(first_fail_idx), 32'd0);
                chk({name, ":rst_ffv"}, 32'(first_fail_vld), 32'd0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                for (int w = 0; w < 60; w++) begin
                    @(negedge clk);
                    if (done || busy || stim != 4'd0) begin
                        chk({name, ":idle_after_rst"}, {29'd0, done, busy, |stim}, 32'd0);
                        return;
                    end
                end
                chk({name, ":idle_after_rst"}, {29'd0, done, busy, |stim}, 32'd0);
                return;
            end
            if (pulse10 && k == 9)  start = 1'b1;  // sampled at E0+10
            if (pulse10 && k == 10) start = 1'b0;
            if (k < 48) begin
                // each vector must be held SETTLE+1 = 3 cycles, stepping 0..15
                if (hold == 3) begin
                    hold = 0;
                    expect_stim++;
                end
                hold++;
                chk($sformatf("%s:stim@%0d", name, k), 32'(stim), 32'(expect_stim));
                chk($sformatf("%s:busy@%0d", name, k), {30'd0, busy, done}, 32'd2);
            end
        end
        chk({name, ":done"}, 32'(done), 32'd1);
        chk({name, ":busy_end"}, 32'(busy), 32'd0);
        chk({name, ":stim_end"}, 32'(stim), 32'd15);
        chk({name, ":err"}, 32'(err_count), 32'(exp_err));
        chk({name, ":ffv"}, 32'(first_fail_vld), 32'(exp_ffv));
        chk({name, ":ffi"}, 32'(first_fail_idx), 32'(exp_ffi));
        chk({name, ":pass"}, 32'(pass), 32'(exp_err == 0));
        // results hold while start stays low
        repeat (5) @(posedge clk);
        #1;
        chk({name, ":done_hold"}, 32'(done), 32'd1);
        chk({name, ":err_hold"}, 32'(err_count), 32'(exp_err));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            gold_tbl[i] = ((i >> 3) & (i >> 2) & (i >> 1) & i & 1) == 1;
        end
        resp_tbl = gold_tbl;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stim", 32'(stim), 32'd0);
        chk("reset_flags", {28'd0, busy, done, pass, first_fail_vld}, 32'd0);
        chk("reset_err", 32'(err_count), 32'd0);
        chk("reset_ffi", 32'(first_fail_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: golden block
        resp_tbl = gold_tbl;
        run_sweep("golden", 1'b0, 1'b0);

        // 2: output stuck at 1
        resp_tbl = 16'hFFFF;
        run_sweep("stuck1", 1'b0, 1'b0);

        // 6: restart from DONE with golden block clears previous errors
        resp_tbl = gold_tbl;
        run_sweep("rerun_golden", 1'b0, 1'b0);

        // 3: golden with vector 9 inverted
        resp_tbl = gold_tbl;
        resp_tbl[9] = ~resp_tbl[9];
        run_sweep("flip9", 1'b0, 1'b0);

        // 5: extra start pulse while busy is ignored
        resp_tbl = gold_tbl;
        resp_tbl[4] = ~resp_tbl[4];
        run_sweep("start_busy", 1'b1, 1'b0);

        // 4: reset mid-sweep (stuck block so counters are nonzero beforehand)
        resp_tbl = 16'hFFFF;
        run_sweep("midreset", 1'b0, 1'b1);

        // randomized truth tables
        for (int r = 0; r < 4; r++) begin
            resp_tbl = 16'($urandom);
            run_sweep($sformatf("rand%0d", r), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
